// File: rtl/ring_arb_pkg.sv
// Shared definitions for the ring round-robin arbiter: FSM encoding and
// combinational helpers for one-hot indexing and the circular priority scan.
package ring_arb_pkg;

  localparam int MAX_N     = 32;
  localparam int MAX_IDX_W = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_N-1:0] v);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

  // First set request bit scanning upward from the ptr position, wrapping at n.
  function automatic logic [MAX_N-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                              input logic [MAX_N-1:0] ptr,
                                              input int n);
    logic [MAX_N-1:0]     win;
    logic [MAX_IDX_W-1:0] start;
    logic                 found;
    int                   pos;
    win   = '0;
    found = 1'b0;
    start = onehot2idx(ptr);
    for (int i = 0; i < MAX_N; i++) begin
      pos = int'(start) + i;
      if (pos >= n) pos = pos - n;
      if (i < n && !found && req[pos[MAX_IDX_W-1:0]]) begin
        win[pos[MAX_IDX_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/ring_arb_ptr.sv
// One-hot priority ring: resets to bit 0 and loads the finished grant rotated
// left by one so the next requester above the old owner gets top priority.
module ring_ptr #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] grant,
  output logic [N-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= N'(1);
    end else if (load) begin
      ptr <= {grant[N-2:0], grant[N-1]};
    end
  end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, mandatory turnaround
// cycle between owners and an optional per-owner hold limit.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDX_W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             rel,        // owner release pulse ("release" is reserved)
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             timeout,
  output logic [N-1:0]     ptr
);

  localparam int HC_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam bit HOLD_EN = (MAX_HOLD != 0);

  state_t           state, state_nx;
  logic [N-1:0]     grant_nx;
  logic [IDX_W-1:0] grant_idx_nx;
  logic             timeout_nx;
  logic [HC_W-1:0]  hold_cnt, hold_nx;
  logic             ptr_load;

  logic [MAX_N-1:0]     req_ext, ptr_ext, pick;
  logic [MAX_IDX_W-1:0] pick_idx;
  logic                 exit_rel, exit_drop, exit_to;

  always_comb begin
    req_ext = '0;
    ptr_ext = '0;
    req_ext[N-1:0] = req;
    ptr_ext[N-1:0] = ptr;
    pick     = rr_pick(req_ext, ptr_ext, N);
    pick_idx = onehot2idx(pick);
  end

  assign exit_rel  = rel;
  assign exit_drop = ~|(req & grant);
  assign exit_to   = HOLD_EN && (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nx     = state;
    grant_nx     = grant;
    grant_idx_nx = grant_idx;
    timeout_nx   = 1'b0;
    hold_nx      = hold_cnt;
    ptr_load     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          state_nx     = ST_BUSY;
          grant_nx     = pick[N-1:0];
          grant_idx_nx = pick_idx[IDX_W-1:0];
          hold_nx      = '0;
        end
      end
      ST_BUSY: begin
        if (exit_rel || exit_drop || exit_to) begin
          state_nx     = ST_IDLE;
          grant_nx     = '0;
          grant_idx_nx = '0;
          ptr_load     = 1'b1;
          // A coinciding release or request drop counts as a normal exit.
          timeout_nx   = exit_to && !exit_rel && !exit_drop;
        end else if (HOLD_EN && hold_cnt != HOLD_LAST) begin
          hold_nx = hold_cnt + HC_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant     <= '0;
      grant_idx <= '0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nx;
      grant     <= grant_nx;
      grant_idx <= grant_idx_nx;
      timeout   <= timeout_nx;
      hold_cnt  <= hold_nx;
    end
  end

  assign busy = (state == ST_BUSY);

  ring_ptr #(.N(N)) u_ring_ptr (
    .clk   (clk),
    .rst   (rst),
    .load  (ptr_load),
    .grant (grant),
    .ptr   (ptr)
  );

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter (N=4, MAX_HOLD=8) with hand-computed
// expectations checked one cycle at a time.
module tb_ring_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       rel;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;
  logic       timeout;
  logic [3:0] ptr;

  int checks = 0;
  int passed = 0;

  ring_rr_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rel       (rel),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout),
    .ptr       (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
      $error("%s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Full snapshot of the visible outputs.
  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] gi,
                            input logic b, input logic t, input logic [3:0] p);
    check({tag, ".grant"},     32'(grant),     32'(g));
    check({tag, ".grant_idx"}, 32'(grant_idx), 32'(gi));
    check({tag, ".busy"},      32'(busy),      32'(b));
    check({tag, ".timeout"},   32'(timeout),   32'(t));
    check({tag, ".ptr"},       32'(ptr),       32'(p));
  endtask

  logic [3:0] rot_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] rot_i [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] rot_p [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    rel = 1'b0;

    // Reset held two edges with all requests pending.
    tick();
    expect_out("rst1", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0001);
    tick();
    expect_out("rst2", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0001);
    rst = 1'b0;
    tick();
    expect_out("rst_exit", 4'b0001, 2'd0, 1'b1, 1'b0, 4'b0001);

    // Full rotation: release on the 3rd grant cycle of each owner.
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      check("rot.held", 32'(grant), 32'(rot_g[k]));
      rel = 1'b1;
      tick();
      rel = 1'b0;
      expect_out("rot.gap", 4'b0000, 2'd0, 1'b0, 1'b0, rot_p[k]);
      tick();
      expect_out("rot.next", rot_g[k+1], rot_i[k+1], 1'b1, 1'b0, rot_p[k]);
    end
    req = 4'b0000;
    tick();
    expect_out("rot.drop", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0010);
    tick();
    expect_out("rot.idle", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0010);

    // Wrap-around of the priority ring.
    rst = 1'b1;
    tick();
    check("wrap.rst_ptr", 32'(ptr), 32'(4'b0001));
    rst = 1'b0;
    req = 4'b0100;
    tick();
    expect_out("wrap.g2", 4'b0100, 2'd2, 1'b1, 1'b0, 4'b0001);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    req = 4'b0001;
    expect_out("wrap.gap", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b1000);
    tick();
    expect_out("wrap.g0", 4'b0001, 2'd0, 1'b1, 1'b0, 4'b1000);
    req = 4'b0000;
    tick();
    expect_out("wrap.drop", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0010);

    // Hold timeout after 8 grant cycles, then immediate re-grant.
    req = 4'b0010;
    tick();
    check("to.cycle1", 32'(grant), 32'(4'b0010));
    for (int i = 2; i <= 8; i++) begin
      tick();
      check("to.held", 32'(grant), 32'(4'b0010));
      check("to.no_pulse", 32'(timeout), 32'(1'b0));
    end
    tick();
    expect_out("to.exit", 4'b0000, 2'd0, 1'b0, 1'b1, 4'b0100);
    tick();
    expect_out("to.regrant", 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0100);

    // Release coinciding with the hold limit is a normal exit.
    for (int i = 2; i <= 8; i++) tick();
    rel = 1'b1;
    tick();
    rel = 1'b0;
    expect_out("sim.rel8", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0100);
    tick();
    check("sim.regrant", 32'(grant), 32'(4'b0010));

    // Owner drops its request on the 4th grant cycle.
    tick();
    tick();
    tick();
    req = 4'b0000;
    tick();
    expect_out("sim.drop4", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0100);

    // Reset in the middle of a grant.
    req = 4'b1000;
    tick();
    expect_out("mid.grant", 4'b1000, 2'd3, 1'b1, 1'b0, 4'b0100);
    rst = 1'b1;
    tick();
    expect_out("mid.rst", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0001);
    rst = 1'b0;
    tick();
    expect_out("mid.regrant", 4'b1000, 2'd3, 1'b1, 1'b0, 4'b0001);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ring_rr_arbiter.md
Name: ring_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource between N requesters.
- Priority is held in a one-hot rotating ring pointer, i.e. a loadable ring counter.
- Grants are one-hot, registered and held until the owner releases, drops its request, or hits a hold timeout.
- Sits in front of any shared sequential datapath (counter, bus, register bank) in the Day 7 sequential-controller set.

Parameters:
- N, 4, number of requesters (≥2).
- MAX_HOLD, 8, maximum consecutive grant cycles per owner; 0 disables the timeout.
- IDX_W, $clog2(N), width of grant_idx (derived, do not override).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-requester request, level-sensitive.
- release  input  1  owner finished, single-cycle pulse; ignored when not busy.
- grant  output  N  one-hot grant, registered; all-zero when idle.
- grant_idx  output  IDX_W  binary index of the current owner; 0 when idle.
- busy  output  1  high while grant ≠ 0.
- timeout  output  1  one-cycle pulse when a grant is withdrawn by the hold limit.
- ptr  output  N  current one-hot priority ring, for observation.

Behaviour:
- Reset, sampled at posedge with rst=1:
  - grant=0, grant_idx=0, busy=0, timeout=0.
  - ptr=0…01 (bit 0), hold_cnt=0, state=IDLE.
  - rst mid-grant takes effect at that edge and has priority over everything else.
- States: IDLE and BUSY; 2-state FSM with registered outputs.
- IDLE:
  - If req≠0, the winner is the first set req bit scanning circularly from the ptr position upward, wrapping N-1→0.
  - Next edge: grant=winner, grant_idx=index, busy=1, hold_cnt=0, state→BUSY.
  - Latency from req to grant is 1 cycle.
  - If req=0, stay in IDLE; outputs unchanged.
- BUSY: grant is held constant. Exit cause is evaluated each edge:
  - (a) release=1;
  - (b) req[owner]=0;
  - (c) MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1.
- If no exit cause is present: hold_cnt increments, saturating at MAX_HOLD-1.
- On exit (any cause), at the next edge:
  - grant=0, grant_idx=0, busy=0, state→IDLE.
  - ptr = grant rotated left by 1, so the owner+1 gets top priority (N-1 wraps to bit 0).
  - timeout=1 only when (c) is the sole cause. If (a) or (b) coincides with (c), it counts as a normal release and timeout=0.
- Mandatory one idle (turnaround) cycle between consecutive grants, even with requests pending: release at edge t → grant=0 after edge t, next grant after edge t+1.
- timeout is high for exactly the turnaround cycle after a timeout exit.
- A requester that is timed out is re-eligible immediately; it gets re-granted only if no lower-rotation requester is pending.
- ptr changes only on BUSY exit or reset, and is always exactly one-hot.
- grant is always zero or one-hot; grant_idx is always consistent with grant.
- Requests arriving or changing while BUSY do not affect the current grant, except the owner's own bit (exit cause b).
- With MAX_HOLD=0 the hold_cnt logic is inert and timeout stays 0.

Decomposition:
- Shared header/package ring_arb_pkg:
  - state encoding localparams ST_IDLE=1'b0, ST_BUSY=1'b1;
  - function onehot2idx (one-hot → binary);
  - function rr_pick(req, ptr) (circular first-set scan).
- One sub-module, ring_ptr:
  - N-bit one-hot register with rst→bit 0;
  - load-rotated-grant input and enable;
  - output ptr.
  - Reuses the team's ring-counter structure.
- Top level holds the FSM, the hold counter and the output registers.

Test Plan:
All cases use N=4, MAX_HOLD=8.
- Reset: rst=1 for 2 cycles, req=1111 → grant=0000, busy=0, ptr=0001, timeout=0 throughout reset; grant=0001 one cycle after rst falls.
- Full rotation: req=1111 held, release pulsed on the 3rd grant cycle of each owner → grant sequence 0001,0010,0100,1000,0001, each separated by exactly one 0000 cycle; ptr 0010,0100,1000,0001 after each exit.
- Wrap-around: from reset, req=0100 only → grant 0100 after 1 cycle. Release → ptr=1000. Then req=0001 → grant 0001, grant_idx=0.
- Timeout: req=0010 held, no release → grant=0010 for exactly 8 cycles, then grant=0000 with timeout=1 for 1 cycle, ptr=0100; next cycle grant=0010 again.
- Simultaneous exit: release=1 on the 8th grant cycle → timeout stays 0. Owner drops req on the 4th cycle (req 0010→0000) → grant=0000 next cycle, timeout=0.
- Reset mid-grant: grant=1000, ptr=0100, rst=1 for one edge → grant=0000, ptr=0001, busy=0 after that edge; pending req=1000 re-granted 1 cycle after rst falls.
